// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module  : uart_tx_pkg
// Purpose : Shared constants and helpers for the UART transmitter slice.
//           Baud divisors are clk cycles per serial bit at a 12 MHz system
//           clock (ICEstick). The frame helper builds the 8N1 shift image.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  // Clock cycles per bit for common baud rates at 12 MHz
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;
  localparam int B4800   = 2500;
  localparam int B2400   = 5000;
  localparam int B1200   = 10000;
  localparam int B600    = 20000;
  localparam int B300    = 40000;

  // Frame layout: start + 8 data + stop
  localparam int         FRAME_BITS   = 10;
  localparam logic [3:0] BITCNT_LAST  = 4'd9;   // index of the stop bit
  localparam logic [3:0] BITCNT_SAT   = 4'd10;  // counter saturation value

  // 8N1 image as shifted out LSB first: bit 0 = start (0), bit 9 = stop (1)
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] ch);
    return {1'b1, ch, 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_baudgen.sv
// ============================================================================
// Module  : baudgen_tx
// Purpose : Bit-period generator for the transmitter. Counts clk cycles while
//           enabled and emits a single-cycle tick on the last cycle of each
//           bit period. Held at zero while disabled, so enabling it starts a
//           fresh, full-length period.
// Ports   : clk     - system clock (rising edge)
//           rstn    - synchronous active-low reset
//           clk_ena - count enable (high while a frame is in progress)
//           clk_out - one-cycle tick at the end of each bit period
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module baudgen_tx
  import uart_tx_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic clk,
  input  logic rstn,
  input  logic clk_ena,
  output logic clk_out
);

  localparam int            CNT_W   = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BAUDRATE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!clk_ena) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TOP) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign clk_out = clk_ena && (cnt_q == CNT_TOP);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module  : uart_tx
// Purpose : 8N1 UART transmitter. A request is accepted when start=1 while
//           ready=1; the character is latched with start/stop bits into a
//           10-bit shift register whose LSB drives the serial line directly,
//           so tx is a flop output. Each bit lasts BAUDRATE clk cycles.
// Ports   : clk   - system clock (rising edge)
//           rstn  - synchronous active-low reset
//           start - transmit request, honoured only while ready=1
//           data  - character to send, sampled in the accept cycle
//           tx    - serial output, idle high
//           ready - 1 when idle and a request will be accepted
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_TRANS = 1'b1;

  logic                  state_q;
  logic                  state_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_d;
  logic [3:0]            bitcnt_q;
  logic [3:0]            bitcnt_d;
  logic                  ready_q;
  logic                  ready_d;

  logic                  accept;
  logic                  baud_ena;
  logic                  baud_tick;

  baudgen_tx #(
    .BAUDRATE (BAUDRATE)
  ) u_baudgen (
    .clk     (clk),
    .rstn    (rstn),
    .clk_ena (baud_ena),
    .clk_out (baud_tick)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= STATE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // The last tick arrives at the end of the stop bit, when the counter still
  // holds 9; leaving here makes ready rise right after the stop period.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_IDLE: begin
        if (accept) begin
          state_d = STATE_TRANS;
        end
      end
      STATE_TRANS: begin
        if (baud_tick && (bitcnt_q == BITCNT_LAST)) begin
          state_d = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // ready is registered so it is low in the first cycle after reset release
  // and any start seen then is ignored rather than accepted.
  // --------------------------------------------------------------------------
  always_comb begin
    accept   = (state_q == STATE_IDLE) && ready_q && start;
    baud_ena = (state_q == STATE_TRANS);
    ready_d  = (state_d == STATE_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register and bit counter
  // Ones shift in at the MSB, so the register is all ones once the stop bit
  // has gone out and tx naturally idles high.
  // --------------------------------------------------------------------------
  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      shift_d  = build_frame(data);
      bitcnt_d = 4'd0;
    end else if (state_q == STATE_TRANS) begin
      if (baud_tick) begin
        shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
        if (bitcnt_q != BITCNT_SAT) begin
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end
    end else begin
      bitcnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_q  <= '1;
      bitcnt_q <= 4'd0;
      ready_q  <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      ready_q  <= ready_d;
    end
  end

  assign tx    = shift_q[0];
  assign ready = ready_q;

endmodule

`default_nettype wire
